// File: rtl/mm4_pkg.sv
// Shared defaults, FSM encoding and score type for the MM4 result readout controller.
package mm4_pkg;

  localparam int MM4_NUM_CLASSES = 10;
  localparam int MM4_DATA_W      = 32;
  localparam int MM4_ADDR_W      = 16;
  localparam int MM4_IDX_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_FIN  = 2'd2
  } mm4_state_t;

  typedef logic signed [MM4_DATA_W-1:0] mm4_score_t;

endpackage

// File: rtl/mm4_argmax_cmp.sv
// Running-maximum register with signed comparator; ties keep the earliest index.
module mm4_argmax_cmp
  import mm4_pkg::*;
#(
  parameter int DATA_W = MM4_DATA_W,
  parameter int IDX_W  = MM4_IDX_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     init,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] score,
  input  logic        [IDX_W-1:0]  idx,
  output logic        [IDX_W-1:0]  max_idx,
  output logic signed [DATA_W-1:0] max_score
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_idx   <= '0;
      max_score <= '0;
    end else if (init) begin
      max_idx   <= idx;
      max_score <= score;
    end else if (en && (score > max_score)) begin
      max_idx   <= idx;
      max_score <= score;
    end
  end

endmodule

// File: rtl/mm4_readout_ctrl.sv
// Argmax scan over the MM4 result memory plus an idle-time host read port.
// Define MM4_SCORE_OUT_EN to also export the winning score on max_score.
//
// state | meaning
// IDLE  | waiting for start; host reads are served here only
// SCAN  | one entry per cycle, addresses 0..NUM_CLASSES-1, producer write-locked
// FIN   | scan complete; class_idx/done update on the way back to IDLE
module mm4_readout_ctrl
  import mm4_pkg::*;
#(
  parameter int NUM_CLASSES = MM4_NUM_CLASSES,
  parameter int DATA_W      = MM4_DATA_W,
  parameter int ADDR_W      = MM4_ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [3:0]               class_idx,
  output logic                     wr_lock,
  output logic        [ADDR_W-1:0] mem_read_addr,
  input  logic signed [DATA_W-1:0] mem_data,
  input  logic                     host_rd_req,
  input  logic        [ADDR_W-1:0] host_rd_addr,
  output logic                     host_rd_ack,
  output logic signed [DATA_W-1:0] host_rd_data,
  output logic                     host_rd_err
`ifdef MM4_SCORE_OUT_EN
  ,
  output logic signed [DATA_W-1:0] max_score
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_CLASSES - 1);
  localparam logic [ADDR_W-1:0] NUM_ADDR  = ADDR_W'(NUM_CLASSES);

  mm4_state_t state, state_nxt;
  logic [ADDR_W-1:0] scan_addr;
  logic host_go, host_hit;
  logic [MM4_IDX_W-1:0] cmp_max_idx;
  logic signed [DATA_W-1:0] cmp_max_score;

  // Holding off while ack is high stops a still-asserted request being served twice.
  assign host_go  = (state == ST_IDLE) && host_rd_req && !start && !host_rd_ack;
  assign host_hit = (host_rd_addr < NUM_ADDR);
  assign busy     = (state == ST_SCAN);
  assign wr_lock  = (state == ST_SCAN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    mem_read_addr = '0;
    case (state)
      ST_IDLE: begin
        if (start)                    state_nxt = ST_SCAN;
        else if (host_go && host_hit) mem_read_addr = host_rd_addr;
      end
      ST_SCAN: begin
        mem_read_addr = scan_addr;
        if (scan_addr == LAST_ADDR) state_nxt = ST_FIN;
      end
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_addr    <= '0;
      done         <= 1'b0;
      class_idx    <= '0;
      host_rd_ack  <= 1'b0;
      host_rd_err  <= 1'b0;
      host_rd_data <= '0;
    end else begin
      scan_addr   <= (state == ST_SCAN) ? scan_addr + ADDR_W'(1) : '0;
      done        <= (state == ST_FIN);
      if (state == ST_FIN) class_idx <= cmp_max_idx;
      host_rd_ack <= host_go;
      host_rd_err <= host_go && !host_hit;
      if (host_go) host_rd_data <= host_hit ? mem_data : '0;
    end
  end

  mm4_argmax_cmp #(
    .DATA_W (DATA_W),
    .IDX_W  (MM4_IDX_W)
  ) u_argmax (
    .clk       (clk),
    .rst_n     (rst_n),
    .init      ((state == ST_SCAN) && (scan_addr == '0)),
    .en        (state == ST_SCAN),
    .score     (mem_data),
    .idx       (scan_addr[MM4_IDX_W-1:0]),
    .max_idx   (cmp_max_idx),
    .max_score (cmp_max_score)
  );

`ifdef MM4_SCORE_OUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                max_score <= '0;
    else if (state == ST_FIN)  max_score <= cmp_max_score;
  end
`else
  logic unused_cmp_score;
  assign unused_cmp_score = ^cmp_max_score;
`endif

endmodule
